multicycle_ctrl: RTL
====================

# multicycle_ctrl

Parametrised multi-cycle control unit for the MIPS datapath. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the existing datapath control signals (RegDst, ALUSrc, ExtOp, ALU control, memory and register strobes) per state. It adds:
- memory ready handshaking with a bounded wait-state timeout;
- a sticky fault state for illegal instructions and timeouts;
- a retired-instruction counter.

It sits between the instruction register and the datapath muxes.

## Interface
Parameters:
- CNT_W, 32: width of retired-instruction counter.
- TIMEOUT, 16: maximum cycles spent waiting on mem_ready before fault; must be ≥1.
- TO_W, 5: width of the wait counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- clk in 1: clock.
- rst in 1: synchronous active-high reset.
- opcode in 6: IR[31:26]; stable from DECODE until instruction end.
- funct in 6: IR[5:0].
- zero in 1: ALU zero flag, valid in EXEC.
- mem_ready in 1: memory completes current request this cycle.
- mem_rd out 1: memory read request (fetch or lw).
- mem_wr out 1: memory write request (sw).
- ir_we out 1: load IR.
- pc_we out 1: write PC.
- pc_src out 2: 00 PC+4, 01 branch target, 10 jump target, 11 rs.
- reg_we out 1: register file write.
- reg_dst out 2: 00 rd, 01 rt, 10 $31.
- mem2reg out 1: writeback from memory.
- alu_src out 2: bit0 imm, bit1 shamt.
- ext_op out 2: EXT_ZERO / EXT_SIGNED / EXT_HIGHPOS.
- alu_ctrl out 5: ALUOp_* code.
- state out 3: current state.
- fault out 1: sticky error flag.
- fault_code out 2: 01 illegal, 10 timeout.
- instr_cnt out CNT_W: retired instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- Outputs are combinational from state, opcode and funct. Every strobe not listed for a state is 0.
- FETCH:
  - mem_rd=1.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Legal opcode/funct go to EXEC.
  - Illegal ones go to FAULT with code 01.
  - Legal set: R-type addu/add/subu/sub/slt/sll/srl/sra/and/or/jr; ori, addi, slti, lui, lw, sw, beq, bne, j, jal.
- EXEC:
  - alu_ctrl, alu_src and ext_op are driven per instruction, identical to the single-cycle decode.
  - R/I arithmetic and lui go to WB.
  - lw/sw go to MEM.
  - beq: pc_we=zero, pc_src=01. bne: pc_we=!zero, pc_src=01. Both retire, then go to FETCH.
  - j: pc_we=1, pc_src=10, retire, then FETCH.
  - jr: pc_we=1, pc_src=11, retire, then FETCH.
  - jal: pc_we=1, pc_src=10, reg_we=1, reg_dst=10, retire, then FETCH.
- MEM:
  - lw: mem_rd=1; on mem_ready go to WB.
  - sw: mem_wr=1; on mem_ready retire and go to FETCH.
- WB:
  - reg_we=1. reg_dst is 00 for R-type, else 01.
  - mem2reg=1 for lw.
  - Retire, then go to FETCH.
- Wait counter:
  - Cleared on entering FETCH or MEM.
  - Increments each cycle mem_ready=0 in those states.
  - When it reaches TIMEOUT with mem_ready still 0, go to FAULT with code 10.
  - mem_ready on the same cycle wins over timeout.
- FAULT:
  - All strobes 0. fault=1 and fault_code hold.
  - Only rst leaves this state.
- Retire means instr_cnt+1 on the clock edge; it wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH, instr_cnt=0, fault=0, fault_code=00, wait counter=0. On the first cycle after reset mem_rd=1; all other strobes are 0.
- rst is sampled every edge and overrides any state, including mid-MEM wait and FAULT. An in-flight write is abandoned with mem_wr deasserted next cycle.
- Zero-wait memory (mem_ready=1 whenever requested), cycles per instruction:
  - branch/j/jr/jal: 3
  - R-type/ALU-immediate/lui: 4
  - sw: 4
  - lw: 5
- Each cycle mem_ready=0 in FETCH or MEM adds one cycle.
- mem_ready is ignored outside FETCH and MEM.
- instr_cnt updates on the retiring edge and is visible in the next FETCH cycle.

## Structure
- State encodings, pc_src/reg_dst codes and fault codes go into the shared ctrl_encode_def.v.
- Opcode/funct values come from instruction_def.v.
- ALUOp_* and EXT_* codes come from ctrl_encode_def.v.
- Sub-module insn_decode is purely combinational. It takes opcode and funct and returns alu_ctrl, alu_src, ext_op, an instruction class (ALU, LOAD, STORE, BRANCH_EQ, BRANCH_NE, JUMP, JR, JAL) and a legal flag.
- The FSM, wait counter and retire counter live in multicycle_ctrl.

## Test plan
- addu (op 000000, funct 100001), mem_ready tied 1 → states 0,1,2,4,0; reg_we=1 only in WB with reg_dst=00; instr_cnt 0→1.
- lw (op 100011) with mem_ready low 3 cycles in MEM → mem_rd held 4 cycles, then WB with mem2reg=1; 8 cycles total.
- beq (op 000100) with zero=0, then beq with zero=1 → pc_we in EXEC 0 then 1 with pc_src=01; each takes 3 cycles; instr_cnt +2.
- jal (op 000011) → EXEC has pc_we=1, pc_src=10, reg_we=1, reg_dst=10.
- TIMEOUT=4, mem_ready held 0 in FETCH → FAULT after 4 wait cycles with fault_code=10; stays there 20 cycles; rst pulse returns to FETCH with fault=0.
- opcode 111111 → FAULT with fault_code=01. Separately, CNT_W=4 with 16 jr instructions → instr_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// datapath mux codes, fault codes, ALU/extender codes and the ISA subset.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BNE,
        CLS_JUMP,
        CLS_JR,
        CLS_JAL
    } insn_class_e;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    localparam logic [1:0] REG_DST_RD = 2'b00;
    localparam logic [1:0] REG_DST_RT = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam logic [1:0] ALU_SRC_REG   = 2'b00;
    localparam logic [1:0] ALU_SRC_IMM   = 2'b01;
    localparam logic [1:0] ALU_SRC_SHAMT = 2'b10;

    localparam logic [1:0] EXT_ZERO    = 2'b00;
    localparam logic [1:0] EXT_SIGNED  = 2'b01;
    localparam logic [1:0] EXT_HIGHPOS = 2'b10;

    localparam logic [4:0] ALUOp_NOP  = 5'd0;
    localparam logic [4:0] ALUOp_ADDU = 5'd1;
    localparam logic [4:0] ALUOp_ADD  = 5'd2;
    localparam logic [4:0] ALUOp_SUBU = 5'd3;
    localparam logic [4:0] ALUOp_SUB  = 5'd4;
    localparam logic [4:0] ALUOp_AND  = 5'd5;
    localparam logic [4:0] ALUOp_OR   = 5'd6;
    localparam logic [4:0] ALUOp_SLT  = 5'd7;
    localparam logic [4:0] ALUOp_SLL  = 5'd8;
    localparam logic [4:0] ALUOp_SRL  = 5'd9;
    localparam logic [4:0] ALUOp_SRA  = 5'd10;
    localparam logic [4:0] ALUOp_LUI  = 5'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

endpackage

// File: rtl/multicycle_ctrl_insn_decode.sv
// Purely combinational instruction decoder: ALU controls, instruction
// class and legality flag derived from opcode and funct.
module insn_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    output logic [4:0]  alu_ctrl_o,
    output logic [1:0]  alu_src_o,
    output logic [1:0]  ext_op_o,
    output insn_class_e insn_class_o,
    output logic        legal_o
);

    // Decode table; anything not matched stays illegal with neutral controls
    always_comb begin
        alu_ctrl_o   = ALUOp_NOP;
        alu_src_o    = ALU_SRC_REG;
        ext_op_o     = EXT_ZERO;
        insn_class_o = CLS_ALU;
        legal_o      = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: alu_ctrl_o = ALUOp_ADDU;
                    FN_ADD:  alu_ctrl_o = ALUOp_ADD;
                    FN_SUBU: alu_ctrl_o = ALUOp_SUBU;
                    FN_SUB:  alu_ctrl_o = ALUOp_SUB;
                    FN_SLT:  alu_ctrl_o = ALUOp_SLT;
                    FN_AND:  alu_ctrl_o = ALUOp_AND;
                    FN_OR:   alu_ctrl_o = ALUOp_OR;
                    FN_SLL: begin
                        alu_ctrl_o = ALUOp_SLL;
                        alu_src_o  = ALU_SRC_SHAMT;
                    end
                    FN_SRL: begin
                        alu_ctrl_o = ALUOp_SRL;
                        alu_src_o  = ALU_SRC_SHAMT;
                    end
                    FN_SRA: begin
                        alu_ctrl_o = ALUOp_SRA;
                        alu_src_o  = ALU_SRC_SHAMT;
                    end
                    FN_JR:   insn_class_o = CLS_JR;
                    default: legal_o = 1'b0;
                endcase
            end
            OP_ORI: begin
                alu_ctrl_o = ALUOp_OR;
                alu_src_o  = ALU_SRC_IMM;
                ext_op_o   = EXT_ZERO;
            end
            OP_ADDI: begin
                alu_ctrl_o = ALUOp_ADD;
                alu_src_o  = ALU_SRC_IMM;
                ext_op_o   = EXT_SIGNED;
            end
            OP_SLTI: begin
                alu_ctrl_o = ALUOp_SLT;
                alu_src_o  = ALU_SRC_IMM;
                ext_op_o   = EXT_SIGNED;
            end
            OP_LUI: begin
                alu_ctrl_o = ALUOp_LUI;
                alu_src_o  = ALU_SRC_IMM;
                ext_op_o   = EXT_HIGHPOS;
            end
            OP_LW: begin
                alu_ctrl_o   = ALUOp_ADDU;
                alu_src_o    = ALU_SRC_IMM;
                ext_op_o     = EXT_SIGNED;
                insn_class_o = CLS_LOAD;
            end
            OP_SW: begin
                alu_ctrl_o   = ALUOp_ADDU;
                alu_src_o    = ALU_SRC_IMM;
                ext_op_o     = EXT_SIGNED;
                insn_class_o = CLS_STORE;
            end
            OP_BEQ: begin
                alu_ctrl_o   = ALUOp_SUBU;
                ext_op_o     = EXT_SIGNED;
                insn_class_o = CLS_BEQ;
            end
            OP_BNE: begin
                alu_ctrl_o   = ALUOp_SUBU;
                ext_op_o     = EXT_SIGNED;
                insn_class_o = CLS_BNE;
            end
            OP_J:    insn_class_o = CLS_JUMP;
            OP_JAL:  insn_class_o = CLS_JAL;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait-state timeout, sticky
// fault state and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output logic             reg_we_o,
    output logic [1:0]       reg_dst_o,
    output logic             mem2reg_o,
    output logic [1:0]       alu_src_o,
    output logic [1:0]       ext_op_o,
    output logic [4:0]       alu_ctrl_o,
    output logic [2:0]       state_o,
    output logic             fault_o,
    output logic [1:0]       fault_code_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              fault_q;
    logic [1:0]        fault_code_q, fault_code_d;
    logic              retire;
    logic              mem_phase;
    logic              wait_expired;

    logic [4:0]        dec_alu_ctrl;
    logic [1:0]        dec_alu_src;
    logic [1:0]        dec_ext_op;
    insn_class_e       dec_class;
    logic              dec_legal;

    insn_decode u_decode (
        .opcode_i     (opcode_i),
        .funct_i      (funct_i),
        .alu_ctrl_o   (dec_alu_ctrl),
        .alu_src_o    (dec_alu_src),
        .ext_op_o     (dec_ext_op),
        .insn_class_o (dec_class),
        .legal_o      (dec_legal)
    );

    // The timeout fires on the wait cycle that would bring the count to TIMEOUT
    assign mem_phase    = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wait_expired = mem_phase && !mem_ready_i && (wait_q == TO_W'(TIMEOUT - 1));

    // State register; reset overrides everything including FAULT
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a ready memory always beats the timeout
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready_i) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                case (dec_class)
                    CLS_ALU:             state_d = ST_WB;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    state_d = (dec_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                end else if (wait_expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_WB:    state_d = ST_FETCH;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // Per-state datapath strobes and the retire pulse
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_wr_o   = 1'b0;
        ir_we_o    = 1'b0;
        pc_we_o    = 1'b0;
        pc_src_o   = PC_SRC_PC4;
        reg_we_o   = 1'b0;
        reg_dst_o  = REG_DST_RD;
        mem2reg_o  = 1'b0;
        alu_src_o  = ALU_SRC_REG;
        ext_op_o   = EXT_ZERO;
        alu_ctrl_o = ALUOp_NOP;
        retire     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_rd_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                end
            end
            ST_EXEC: begin
                alu_ctrl_o = dec_alu_ctrl;
                alu_src_o  = dec_alu_src;
                ext_op_o   = dec_ext_op;
                case (dec_class)
                    CLS_BEQ: begin
                        pc_we_o  = zero_i;
                        pc_src_o = PC_SRC_BRANCH;
                        retire   = 1'b1;
                    end
                    CLS_BNE: begin
                        pc_we_o  = !zero_i;
                        pc_src_o = PC_SRC_BRANCH;
                        retire   = 1'b1;
                    end
                    CLS_JUMP: begin
                        pc_we_o  = 1'b1;
                        pc_src_o = PC_SRC_JUMP;
                        retire   = 1'b1;
                    end
                    CLS_JR: begin
                        pc_we_o  = 1'b1;
                        pc_src_o = PC_SRC_RS;
                        retire   = 1'b1;
                    end
                    CLS_JAL: begin
                        pc_we_o   = 1'b1;
                        pc_src_o  = PC_SRC_JUMP;
                        reg_we_o  = 1'b1;
                        reg_dst_o = REG_DST_RA;
                        retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                if (dec_class == CLS_LOAD) begin
                    mem_rd_o = 1'b1;
                end
                if (dec_class == CLS_STORE) begin
                    mem_wr_o = 1'b1;
                    retire   = mem_ready_i;
                end
            end
            ST_WB: begin
                reg_we_o  = 1'b1;
                reg_dst_o = (opcode_i == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
                mem2reg_o = (dec_class == CLS_LOAD);
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Wait counter runs only while a memory request is stalled
    assign wait_d = (mem_phase && !mem_ready_i) ? (wait_q + TO_W'(1)) : '0;

    // Wait counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Sticky fault flag and the code captured on entry to FAULT
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            fault_q      <= (state_d == ST_FAULT);
            fault_code_q <= fault_code_d;
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(retire);
        end
    end

    assign state_o      = state_q;
    assign fault_o      = fault_q;
    assign fault_code_o = fault_code_q;
    assign instr_cnt_o  = cnt_q;

endmodule
